// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle fetch / decode / execute controller for a small RV32-style
// register-file + ALU datapath. It fetches one 32-bit instruction at a time
// over a req/valid handshake, decodes it, and drives the register addresses,
// write enable, ALU controls and immediate to the datapath. It also resolves
// conditional branches from the datapath EQ flag and owns the program counter.
//
// Supported instructions: ADDI, ADD, SUB, BEQ, BNE. Every other encoding is
// illegal.
//
// Each instruction takes one FETCH cycle plus any memory wait cycles, then one
// DECODE cycle and one EXECUTE cycle.
//
// Optional feature (compile-time macro ILLEGAL_TRAP_EN):
//   defined   : an illegal instruction stops the core in a HALT state. In HALT,
//               halted=1, pc is frozen, and no further fetches are issued.
//               Only rst leaves HALT.
//   undefined : an illegal instruction executes as a NOP (pc+4, retired
//               pulses, no register write). halted is tied to 0.
//
// Parameters:
//   PC_WIDTH   width of pc / imem_addr (at most 32)
//   RESET_PC   pc value loaded on reset
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   imem_req    out  fetch request, held high until imem_valid
//   imem_addr   out  fetch address, equal to pc
//   imem_valid  in   imem_rdata valid, accepted only while imem_req=1
//   imem_rdata  in   instruction word
//   EQ          in   datapath equality flag (RD1 == ALU operand 2)
//   AD1/AD2/AD3 out  rs1 / rs2 / rd register addresses
//   WE3         out  register write enable (EXECUTE only, never for x0)
//   ALUSrc      out  1 = immediate is ALU operand 2
//   ALUCtrl     out  0 = add, 1 = sub
//   ImmOp       out  sign-extended immediate
//   pc          out  current program counter
//   retired     out  one-cycle pulse while a completing instruction executes
//   halted      out  sticky trap flag (ILLEGAL_TRAP_EN builds only)
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_rdata,
    input  logic                EQ,
    output logic [4:0]          AD1,
    output logic [4:0]          AD2,
    output logic [4:0]          AD3,
    output logic                WE3,
    output logic                ALUSrc,
    output logic                ALUCtrl,
    output logic [31:0]         ImmOp,
    output logic [PC_WIDTH-1:0] pc,
    output logic                retired,
    output logic                halted
);

    // Major opcodes and function fields of the supported instructions.
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2
    } state_t;
`endif

    typedef enum logic [2:0] {
        OP_ADDI,
        OP_ADD,
        OP_SUB,
        OP_BEQ,
        OP_BNE,
        OP_ILL
    } op_t;

    state_t      state;
    logic [31:0] instr;
    op_t         op;        // decoded class of the instruction in EXECUTE
    logic        we3_q;

    // Instruction fields.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // ------------------------------------------------------------------
    // Decode of the latched instruction word. Only used in DECODE, where
    // the results are captured into the datapath-facing registers.
    // ------------------------------------------------------------------
    op_t         dec_op;
    logic [31:0] dec_imm;
    logic        dec_writes;

    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path through the case leaves it unassigned, which would infer a latch.
        dec_op  = OP_ILL;
        dec_imm = '0;
        case (opcode)
            OPC_OPIMM: begin
                if (funct3 == F3_ADD) begin
                    dec_op = OP_ADDI;
                end
            end
            OPC_OP: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    dec_op = OP_ADD;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    dec_op = OP_SUB;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    dec_op = OP_BEQ;
                end else if (funct3 == F3_BNE) begin
                    dec_op = OP_BNE;
                end
            end
            default: ;
        endcase

        // The immediate follows the decoded class, so illegal encodings that
        // happen to share an opcode with a legal one still produce 0.
        case (dec_op)
            OP_ADDI:
                dec_imm = {{20{instr[31]}}, instr[31:20]};
            OP_BEQ, OP_BNE:
                dec_imm = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            default:
                dec_imm = '0;
        endcase
    end

    assign dec_writes = (dec_op == OP_ADDI) || (dec_op == OP_ADD) ||
                        (dec_op == OP_SUB);

    // ------------------------------------------------------------------
    // Branch resolution and next pc, evaluated during EXECUTE.
    // ------------------------------------------------------------------
    logic                taken;
    logic [PC_WIDTH-1:0] pc_next;

    assign taken   = ((op == OP_BEQ) &&  EQ) ||
                     ((op == OP_BNE) && !EQ);
    // Plain modular addition: the pc wraps silently at 2^PC_WIDTH.
    assign pc_next = taken ? pc + PC_WIDTH'(ImmOp) : pc + PC_WIDTH'(4);

    // ------------------------------------------------------------------
    // Sequencer state and all registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples the values from before this edge.
            state   <= S_FETCH;
            pc      <= RESET_PC;
            instr   <= '0;
            op      <= OP_ILL;
            AD1     <= '0;
            AD2     <= '0;
            AD3     <= '0;
            ALUSrc  <= 1'b0;
            ALUCtrl <= 1'b0;
            ImmOp   <= '0;
            we3_q   <= 1'b0;
            retired <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            halted  <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    // imem_req is high throughout FETCH outside reset, so a
                    // valid here is always a response to our request.
                    if (imem_valid) begin
                        instr <= imem_rdata;
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    AD1     <= instr[19:15];
                    AD2     <= instr[24:20];
                    AD3     <= rd;
                    ImmOp   <= dec_imm;
                    ALUSrc  <= (dec_op == OP_ADDI);
                    ALUCtrl <= (dec_op == OP_SUB) || (dec_op == OP_BEQ) ||
                               (dec_op == OP_BNE);
                    op      <= dec_op;
                    // Writes to x0 are suppressed here so WE3 never rises.
                    we3_q   <= dec_writes && (rd != 5'd0);
`ifdef ILLEGAL_TRAP_EN
                    retired <= (dec_op != OP_ILL);
`else
                    retired <= 1'b1;
`endif
                    state   <= S_EXECUTE;
                end

                S_EXECUTE: begin
                    we3_q   <= 1'b0;
                    retired <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
                    if (op == OP_ILL) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc    <= pc_next;
                        state <= S_FETCH;
                    end
`else
                    pc    <= pc_next;
                    state <= S_FETCH;
`endif
                end

`ifdef ILLEGAL_TRAP_EN
                S_HALT: begin
                    state <= S_HALT;
                end
`endif

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

`ifndef ILLEGAL_TRAP_EN
    assign halted = 1'b0;
`endif

    // The request and the write enable are masked by rst itself. A fetch is
    // therefore never offered, and no register write happens, in a reset
    // cycle, even when reset arrives mid-FETCH or mid-EXECUTE.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign WE3       = we3_q && !rst;
    assign imem_addr = pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed testbench for instr_sequencer. The bench acts as the instruction
// memory and the datapath EQ source. Each scenario task drives its own
// stimulus and compares DUT outputs against hand-computed values.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        EQ = 1'b0;
    logic [4:0]  AD1, AD2, AD3;
    logic        WE3, ALUSrc, ALUCtrl;
    logic [31:0] ImmOp;
    logic [31:0] pc;
    logic        retired, halted;

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .EQ         (EQ),
        .AD1        (AD1),
        .AD2        (AD2),
        .AD3        (AD3),
        .WE3        (WE3),
        .ALUSrc     (ALUSrc),
        .ALUCtrl    (ALUCtrl),
        .ImmOp      (ImmOp),
        .pc         (pc),
        .retired    (retired),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Serve one instruction word: wait (bounded) for a request, stall for
    // 'waits' cycles, then return the word. The task returns at the falling
    // edge of the DECODE cycle. req_cycles counts the cycles with imem_req high.
    task automatic fetch(input logic [31:0] word, input int waits,
                         output int req_cycles, output bit ok);
        int guard;
        guard      = 0;
        ok         = 1'b1;
        req_cycles = 0;
        while (imem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < waits; i++) begin
            if (imem_req === 1'b1) req_cycles++;
            imem_valid = 1'b0;
            @(negedge clk);
        end
        if (imem_req === 1'b1) req_cycles++;
        imem_valid = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = '0;
    endtask

    // Fetch with the given EQ value, then advance to the EXECUTE cycle.
    task automatic run_to_exec(input logic [31:0] word, input int waits,
                               input logic eq, output int req_cycles,
                               output bit ok);
        EQ = eq;
        fetch(word, waits, req_cycles, ok);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0);
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        n_checks++;
        if ({WE3, retired, halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got WE3/retired/halted=%b expected 000",
                     {WE3, retired, halted});
        end
        n_checks++;
        if (AD3 !== 5'd0 || ImmOp !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dp: got AD3=%0d ImmOp=%h expected 0/0", AD3, ImmOp);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_fetch: got req=%b addr=%h expected 1/00000000",
                     imem_req, imem_addr);
        end
    endtask

    // ADDI x5,x0,7 with zero-wait memory at pc 0.
    task automatic test_addi;
        int  rc;
        bit  ok;
        EQ = 1'b0;
        fetch(32'h00700293, 0, rc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL addi_fetch: got no request expected imem_req");
        end
        n_checks++;
        if (WE3 !== 1'b0 || imem_req !== 1'b0 || retired !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_decode: got WE3=%b req=%b retired=%b expected 0/0/0",
                     WE3, imem_req, retired);
        end
        @(negedge clk);
        n_checks++;
        if ({AD3, AD1, ALUSrc, ALUCtrl, WE3, retired} !== {5'd5, 5'd0, 4'b1011}) begin
            n_fail++;
            $display("FAIL addi_exec: got AD3=%0d AD1=%0d src=%b ctrl=%b we=%b ret=%b expected 5/0/1/0/1/1",
                     AD3, AD1, ALUSrc, ALUCtrl, WE3, retired);
        end
        n_checks++;
        if (ImmOp !== 32'd7 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL addi_imm: got ImmOp=%h pc=%h expected 00000007/00000000", ImmOp, pc);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h4 || WE3 !== 1'b0 || retired !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_after: got pc=%h WE3=%b retired=%b expected 00000004/0/0",
                     pc, WE3, retired);
        end
    endtask

    // SUB x3,x1,x2 with two memory wait cycles at pc 4.
    task automatic test_sub_wait;
        int rc;
        bit ok;
        run_to_exec(32'h402081B3, 2, 1'b0, rc, ok);
        n_checks++;
        if (!ok || rc != 3) begin
            n_fail++; $display("FAIL sub_req_cycles: got %0d expected 3", rc);
        end
        n_checks++;
        if ({AD1, AD2, AD3} !== {5'd1, 5'd2, 5'd3}) begin
            n_fail++;
            $display("FAIL sub_addr: got %0d/%0d/%0d expected 1/2/3", AD1, AD2, AD3);
        end
        n_checks++;
        if ({ALUCtrl, ALUSrc, WE3} !== 3'b101 || ImmOp !== 32'h0) begin
            n_fail++;
            $display("FAIL sub_exec: got ctrl=%b src=%b we=%b imm=%h expected 1/0/1/00000000",
                     ALUCtrl, ALUSrc, WE3, ImmOp);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h8) begin
            n_fail++; $display("FAIL sub_pc: got %h expected 00000008", pc);
        end
    endtask

    // Starting at pc 8: ADD, BEQ not taken, BNE taken back, BEQ taken, then BNE not taken.
    task automatic test_branch;
        int rc;
        bit ok;
        // ADD x6,x1,x2 : 8 -> C
        run_to_exec(32'h00208333, 0, 1'b0, rc, ok);
        n_checks++;
        if ({AD3, ALUCtrl, ALUSrc, WE3} !== {5'd6, 3'b001}) begin
            n_fail++;
            $display("FAIL add_exec: got AD3=%0d ctrl=%b src=%b we=%b expected 6/0/0/1",
                     AD3, ALUCtrl, ALUSrc, WE3);
        end
        @(negedge clk);
        // BEQ x1,x2,+8 with EQ=0 : C -> 10
        run_to_exec(32'h00208463, 0, 1'b0, rc, ok);
        n_checks++;
        if (ImmOp !== 32'h8 || {ALUCtrl, ALUSrc, WE3} !== 3'b100) begin
            n_fail++;
            $display("FAIL beq_exec: got imm=%h ctrl=%b src=%b we=%b expected 00000008/1/0/0",
                     ImmOp, ALUCtrl, ALUSrc, WE3);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h10) begin
            n_fail++; $display("FAIL beq_not_taken_pc: got %h expected 00000010", pc);
        end
        // BNE x1,x0,-8 with EQ=0 : taken, 10 -> 08
        run_to_exec(32'hFE009CE3, 0, 1'b0, rc, ok);
        n_checks++;
        if (ImmOp !== 32'hFFFFFFF8 || WE3 !== 1'b0 || retired !== 1'b1) begin
            n_fail++;
            $display("FAIL bne_exec: got imm=%h we=%b ret=%b expected fffffff8/0/1",
                     ImmOp, WE3, retired);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h08) begin
            n_fail++; $display("FAIL bne_taken_pc: got %h expected 00000008", pc);
        end
        // BEQ x1,x2,+8 with EQ=1 : taken, 08 -> 10
        run_to_exec(32'h00208463, 0, 1'b1, rc, ok);
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h10) begin
            n_fail++; $display("FAIL beq_taken_pc: got %h expected 00000010", pc);
        end
        // BNE x1,x0,-8 with EQ=1 : not taken, 10 -> 14
        run_to_exec(32'hFE009CE3, 0, 1'b1, rc, ok);
        n_checks++;
        if (WE3 !== 1'b0) begin
            n_fail++; $display("FAIL bne_nt_we3: got %b expected 0", WE3);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h14) begin
            n_fail++; $display("FAIL bne_not_taken_pc: got %h expected 00000014", pc);
        end
    endtask

    // ADDI x0,x0,1 at pc 14: no write, still retires.
    task automatic test_x0_write;
        int rc;
        bit ok;
        run_to_exec(32'h00100013, 0, 1'b0, rc, ok);
        n_checks++;
        if (WE3 !== 1'b0 || retired !== 1'b1 || ImmOp !== 32'h1) begin
            n_fail++;
            $display("FAIL x0_exec: got we=%b ret=%b imm=%h expected 0/1/00000001",
                     WE3, retired, ImmOp);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h18) begin
            n_fail++; $display("FAIL x0_pc: got %h expected 00000018", pc);
        end
    endtask

    // BEQ x0,x0,-28 at pc 18 lands on FFFFFFFC; the next ADDI wraps pc to 0.
    task automatic test_wrap;
        int rc;
        bit ok;
        run_to_exec(32'hFE0002E3, 0, 1'b1, rc, ok);
        n_checks++;
        if (ImmOp !== 32'hFFFFFFE4) begin
            n_fail++; $display("FAIL wrap_imm: got %h expected ffffffe4", ImmOp);
        end
        @(negedge clk);
        n_checks++;
        if (imem_addr !== 32'hFFFFFFFC) begin
            n_fail++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr);
        end
        run_to_exec(32'h00700293, 0, 1'b0, rc, ok);
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc: got %h expected 00000000", pc);
        end
    endtask

    // Illegal word 0xFFFFFFFF at pc 0.
    task automatic test_illegal;
        int rc;
        bit ok;
        int req_seen;
        run_to_exec(32'hFFFFFFFF, 0, 1'b0, rc, ok);
        n_checks++;
        if (WE3 !== 1'b0 || ImmOp !== 32'h0) begin
            n_fail++; $display("FAIL ill_exec: got we=%b imm=%h expected 0/00000000", WE3, ImmOp);
        end
`ifdef ILLEGAL_TRAP_EN
        n_checks++;
        if (retired !== 1'b0) begin
            n_fail++; $display("FAIL ill_retired: got %b expected 0", retired);
        end
        req_seen   = 0;
        imem_valid = 1'b1;
        imem_rdata = 32'h00700293;
        repeat (5) begin
            @(negedge clk);
            if (imem_req !== 1'b0) req_seen++;
        end
        imem_valid = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || pc !== 32'h0 || req_seen != 0) begin
            n_fail++;
            $display("FAIL ill_halt: got halted=%b pc=%h req_cycles=%0d expected 1/00000000/0",
                     halted, pc, req_seen);
        end
`else
        req_seen = 0;
        n_checks++;
        if (retired !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_nop: got retired=%b halted=%b expected 1/0", retired, halted);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h4 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_nop_pc: got pc=%h req=%b expected 00000004/1 (%0d)",
                     pc, imem_req, req_seen);
        end
`endif
    endtask

    // Reset arriving mid-FETCH and mid-EXECUTE.
    task automatic test_reset_mid;
        int rc;
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_to_exec(32'h00700293, 0, 1'b0, rc, ok);
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h4 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got pc=%h req=%b expected 00000004/1", pc, imem_req);
        end
        // One stall cycle, then reset while the memory answers.
        @(negedge clk);
        rst        = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h00700293;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || WE3 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fetch_reset: got req=%b pc=%h we=%b expected 0/00000000/0",
                     imem_req, pc, WE3);
        end
        rst        = 1'b0;
        imem_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_fetch_abandon: got req=%b addr=%h expected 1/00000000",
                     imem_req, imem_addr);
        end
        // ADDI x5 to EXECUTE, then reset during that cycle.
        run_to_exec(32'h00700293, 0, 1'b0, rc, ok);
        n_checks++;
        if (WE3 !== 1'b1) begin
            n_fail++; $display("FAIL mid_exec_we_pre: got %b expected 1", WE3);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (WE3 !== 1'b0) begin
            n_fail++; $display("FAIL mid_exec_we_rst: got %b expected 0", WE3);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 32'h0 || retired !== 1'b0 || WE3 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_exec_reset: got pc=%h ret=%b we=%b expected 00000000/0/0",
                     pc, retired, WE3);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_wait();
        test_branch();
        test_x0_write();
        test_wrap();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
